// File: rtl/rx_pkt_ctrl.sv
// USB receive packet controller: validates the PID, streams payload bytes into a
// 64x8 buffer and holds a good packet for the host, or drops it with an error code.
module rx_pkt_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic       rcving,
  input  logic       w_enable,
  input  logic       r_error,
  input  logic [7:0] rcv_data,
  input  logic       pkt_ack,
  output logic       buf_wr_en,
  output logic [5:0] buf_wr_addr,
  output logic [7:0] buf_wr_data,
  output logic       buf_clear,
  output logic       pkt_valid,
  output logic [3:0] pkt_pid,
  output logic [6:0] pkt_len,
  output logic       pkt_err,
  output logic [1:0] err_code,
  output logic       busy
);

  localparam int unsigned CNT_W = 7;
  localparam logic [CNT_W-1:0] MAX_CNT = 7'd64;

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] PID  = 3'd1;
  localparam logic [2:0] DATA = 3'd2;
  localparam logic [2:0] HOLD = 3'd3;
  localparam logic [2:0] DROP = 3'd4;

  localparam logic [1:0] ERR_NONE = 2'd0;
  localparam logic [1:0] ERR_PID  = 2'd1;
  localparam logic [1:0] ERR_RCV  = 2'd2;
  localparam logic [1:0] ERR_OVF  = 2'd3;

  logic [2:0]       state, state_nxt;
  logic [CNT_W-1:0] count, count_nxt;
  logic             wr_en_nxt;
  logic [5:0]       wr_addr_nxt;
  logic [7:0]       wr_data_nxt;
  logic             clear_nxt;
  logic             valid_nxt;
  logic [3:0]       pid_nxt;
  logic [6:0]       len_nxt;
  logic             perr_nxt;
  logic [1:0]       err_code_nxt;
  logic             busy_nxt;
  logic             pid_ok;

  assign pid_ok = (rcv_data[3:0] == ~rcv_data[7:4]);

  // Next-state and next-output logic; receiver error outranks a same-cycle byte.
  always_comb begin
    state_nxt    = state;
    count_nxt    = count;
    wr_en_nxt    = 1'b0;
    wr_addr_nxt  = buf_wr_addr;
    wr_data_nxt  = buf_wr_data;
    pid_nxt      = pkt_pid;
    len_nxt      = pkt_len;
    err_code_nxt = err_code;

    case (state)
      IDLE: begin
        if (rcving) begin
          state_nxt    = PID;
          count_nxt    = '0;
          err_code_nxt = ERR_NONE;
        end
      end
      PID: begin
        if (r_error) begin
          state_nxt    = DROP;
          err_code_nxt = ERR_RCV;
        end else if (w_enable) begin
          if (pid_ok) begin
            pid_nxt = rcv_data[3:0];
            if (rcving) begin
              state_nxt = DATA;
            end else begin
              state_nxt = HOLD;
              len_nxt   = '0;
            end
          end else begin
            state_nxt    = DROP;
            err_code_nxt = ERR_PID;
          end
        end else if (!rcving) begin
          state_nxt    = DROP;
          err_code_nxt = ERR_RCV;
        end
      end
      DATA: begin
        if (r_error) begin
          state_nxt    = DROP;
          err_code_nxt = ERR_RCV;
        end else if (w_enable && (count == MAX_CNT)) begin
          state_nxt    = DROP;
          err_code_nxt = ERR_OVF;
        end else begin
          if (w_enable) begin
            wr_en_nxt   = 1'b1;
            wr_addr_nxt = count[5:0];
            wr_data_nxt = rcv_data;
            count_nxt   = count + 7'd1;
          end
          // A byte arriving with the falling edge is counted before the length latches.
          if (!rcving) begin
            state_nxt = HOLD;
            len_nxt   = count_nxt;
          end
        end
      end
      HOLD: begin
        if (pkt_ack) state_nxt = IDLE;
      end
      DROP: begin
        if (!rcving) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase

    clear_nxt = (state_nxt == DROP) && (state != DROP);
    perr_nxt  = (state == DROP) && (state_nxt == IDLE);
    valid_nxt = (state_nxt == HOLD);
    busy_nxt  = (state_nxt != IDLE);
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      count       <= '0;
      buf_wr_en   <= 1'b0;
      buf_wr_addr <= '0;
      buf_wr_data <= '0;
      buf_clear   <= 1'b0;
      pkt_valid   <= 1'b0;
      pkt_pid     <= '0;
      pkt_len     <= '0;
      pkt_err     <= 1'b0;
      err_code    <= ERR_NONE;
      busy        <= 1'b0;
    end else begin
      state       <= state_nxt;
      count       <= count_nxt;
      buf_wr_en   <= wr_en_nxt;
      buf_wr_addr <= wr_addr_nxt;
      buf_wr_data <= wr_data_nxt;
      buf_clear   <= clear_nxt;
      pkt_valid   <= valid_nxt;
      pkt_pid     <= pid_nxt;
      pkt_len     <= len_nxt;
      pkt_err     <= perr_nxt;
      err_code    <= err_code_nxt;
      busy        <= busy_nxt;
    end
  end

endmodule

// File: tb/tb_rx_pkt_ctrl.sv
// Directed bench for rx_pkt_ctrl: a packet-level model predicts buffer writes,
// pulses and the held packet; a negedge monitor checks the DUT against it.
module tb_rx_pkt_ctrl;

  logic       clk, rst, rcving, w_enable, r_error, pkt_ack;
  logic [7:0] rcv_data;
  logic       buf_wr_en;
  logic [5:0] buf_wr_addr;
  logic [7:0] buf_wr_data;
  logic       buf_clear, pkt_valid, pkt_err, busy;
  logic [3:0] pkt_pid;
  logic [6:0] pkt_len;
  logic [1:0] err_code;

  typedef struct {
    int         stamp;
    logic [5:0] addr;
    logic [7:0] data;
  } wr_t;

  wr_t        exp_q[$];
  wr_t        cmp_e;
  logic [7:0] wr_log[$];
  logic [7:0] payload [0:79];
  int         cyc, n_pass, n_total, clr_cnt, perr_cnt;
  logic [3:0] exp_pid;
  logic [6:0] exp_len;

  rx_pkt_ctrl dut (
    .clk(clk), .rst(rst), .rcving(rcving), .w_enable(w_enable), .r_error(r_error),
    .rcv_data(rcv_data), .pkt_ack(pkt_ack), .buf_wr_en(buf_wr_en),
    .buf_wr_addr(buf_wr_addr), .buf_wr_data(buf_wr_data), .buf_clear(buf_clear),
    .pkt_valid(pkt_valid), .pkt_pid(pkt_pid), .pkt_len(pkt_len), .pkt_err(pkt_err),
    .err_code(err_code), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Monitor: every write must be the next predicted one, in the predicted cycle.
  always @(negedge clk) begin
    if (buf_wr_en) begin
      wr_log.push_back(buf_wr_data);
      chk("wr_expected", {31'd0, exp_q.size() > 0}, 32'd1);
      if (exp_q.size() > 0) begin
        cmp_e = exp_q.pop_front();
        chk("wr_cycle", 32'(cyc), 32'(cmp_e.stamp));
        chk("wr_addr_data", {18'd0, buf_wr_addr, buf_wr_data}, {18'd0, cmp_e.addr, cmp_e.data});
      end
    end
    if (buf_clear) clr_cnt++;
    if (pkt_err) perr_cnt++;
    if (pkt_valid) begin
      chk("held_pid", 32'(pkt_pid), 32'(exp_pid));
      chk("held_len", 32'(pkt_len), 32'(exp_len));
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic push_wr(input int addr, input logic [7:0] d);
    wr_t e;
    e.stamp = cyc + 1;
    e.addr  = 6'(addr);
    e.data  = d;
    exp_q.push_back(e);
  endtask

  task automatic chk_zero(input string name);
    chk(name, {buf_wr_en, buf_wr_addr, buf_wr_data, buf_clear, pkt_valid, pkt_pid,
               pkt_len, pkt_err, err_code, busy}, 32'd0);
  endtask

  task automatic ack_pkt();
    pkt_ack = 1'b1;
    step();
    pkt_ack = 1'b0;
    chk("valid_after_ack", 32'(pkt_valid), 32'd0);
    chk("busy_after_ack", 32'(busy), 32'd0);
  endtask

  // Sends PID + n payload bytes; r_error rides on payload byte err_at (-1 = none).
  task automatic send_pkt(input logic [7:0] pid, input int n, input int err_at,
                          input bit fall_last, input bit ack_in_data, input bit do_ack);
    bit         pid_ok, ok;
    int         fail_at;
    logic [1:0] ec;
    pid_ok  = (pid[3:0] == ~pid[7:4]);
    fail_at = n;
    ec      = 2'd0;
    if (!pid_ok) begin
      fail_at = 0;
      ec      = 2'd1;
    end else begin
      for (int i = 0; i < n; i++) begin
        if (i == err_at) begin fail_at = i; ec = 2'd2; break; end
        else if (i >= 64) begin fail_at = i; ec = 2'd3; break; end
      end
    end
    ok = pid_ok && (fail_at == n);
    if (ok) begin
      exp_pid = pid[3:0];
      exp_len = 7'(n);
    end
    clr_cnt  = 0;
    perr_cnt = 0;
    wr_log.delete();

    step(); rcving = 1'b1;
    step(); w_enable = 1'b1; rcv_data = pid;
    for (int i = 0; i < n; i++) begin
      step();
      r_error  = 1'b0;
      rcv_data = payload[i];
      pkt_ack  = ack_in_data;
      if (pid_ok && i < fail_at) push_wr(i, payload[i]);
      if (pid_ok && i == fail_at && ec == 2'd2) r_error = 1'b1;
      if (fall_last && i == n - 1) rcving = 1'b0;
    end
    step();
    w_enable = 1'b0; r_error = 1'b0; pkt_ack = 1'b0; rcving = 1'b0;
    step(); step(); step();

    chk("pending_writes", 32'(exp_q.size()), 32'd0);
    if (ok) begin
      chk("valid_held", 32'(pkt_valid), 32'd1);
      chk("busy_hold", 32'(busy), 32'd1);
      chk("err_code_good", 32'(err_code), 32'd0);
      chk("no_clear", 32'(clr_cnt), 32'd0);
      chk("no_pkt_err", 32'(perr_cnt), 32'd0);
      if (do_ack) ack_pkt();
    end else begin
      chk("valid_dropped", 32'(pkt_valid), 32'd0);
      chk("busy_dropped", 32'(busy), 32'd0);
      chk("err_code_drop", 32'(err_code), 32'(ec));
      chk("clear_pulses", 32'(clr_cnt), 32'd1);
      chk("pkt_err_pulses", 32'(perr_cnt), 32'd1);
    end
  endtask

  initial begin
    rst = 1'b1; rcving = 1'b0; w_enable = 1'b0; r_error = 1'b0; pkt_ack = 1'b0;
    rcv_data = 8'h00; exp_pid = 4'h0; exp_len = 7'd0;
    for (int i = 0; i < 80; i++) payload[i] = 8'(i * 37 + 5);

    step(); step();
    chk_zero("reset_outputs");
    rst = 1'b0;
    step();
    chk("idle_busy", 32'(busy), 32'd0);

    // Good packet 0xC3 + 11 22 33
    payload[0] = 8'h11; payload[1] = 8'h22; payload[2] = 8'h33;
    send_pkt(8'hC3, 3, -1, 1'b0, 1'b0, 1'b0);
    chk("lit_pid", 32'(pkt_pid), 32'h3);
    chk("lit_len", 32'(pkt_len), 32'd3);
    chk("lit_wr_count", 32'(wr_log.size()), 32'd3);
    if (wr_log.size() == 3) begin
      chk("lit_wr0", 32'(wr_log[0]), 32'h11);
      chk("lit_wr1", 32'(wr_log[1]), 32'h22);
      chk("lit_wr2", 32'(wr_log[2]), 32'h33);
    end
    ack_pkt();
    for (int i = 0; i < 80; i++) payload[i] = 8'(i * 37 + 5);

    // PID check failure
    send_pkt(8'hC4, 3, -1, 1'b0, 1'b0, 1'b1);
    chk("lit_err_pid", 32'(err_code), 32'd1);
    chk("lit_pidfail_writes", 32'(wr_log.size()), 32'd0);

    // Overflow: 65 payload bytes
    send_pkt(8'h69, 65, -1, 1'b0, 1'b0, 1'b1);
    chk("lit_err_ovf", 32'(err_code), 32'd3);
    chk("lit_ovf_writes", 32'(wr_log.size()), 32'd64);

    // Receiver error collides with second payload byte
    send_pkt(8'hE1, 4, 1, 1'b0, 1'b0, 1'b1);
    chk("lit_err_rcv", 32'(err_code), 32'd2);
    chk("lit_coll_writes", 32'(wr_log.size()), 32'd1);

    // PID-only packet
    send_pkt(8'hD2, 0, -1, 1'b0, 1'b0, 1'b0);
    chk("lit_pidonly_len", 32'(pkt_len), 32'd0);
    chk("lit_pidonly_pid", 32'(pkt_pid), 32'h2);
    ack_pkt();

    // Last byte with the falling edge; ack outside HOLD is ignored
    send_pkt(8'h1E, 2, -1, 1'b1, 1'b1, 1'b0);
    chk("lit_fall_len", 32'(pkt_len), 32'd2);
    ack_pkt();

    // rcving drops while still waiting for the PID byte
    clr_cnt = 0; perr_cnt = 0;
    step(); rcving = 1'b1;
    step(); rcving = 1'b0;
    step(); step(); step();
    chk("lit_nopid_err", 32'(err_code), 32'd2);
    chk("nopid_clear", 32'(clr_cnt), 32'd1);
    chk("nopid_pkt_err", 32'(perr_cnt), 32'd1);
    chk("nopid_busy", 32'(busy), 32'd0);

    // Second packet arriving while one is held
    send_pkt(8'hA5, 2, -1, 1'b0, 1'b0, 1'b0);
    step(); rcving = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step(); w_enable = 1'b1; rcv_data = 8'h5A;
    end
    step(); w_enable = 1'b0; rcving = 1'b0;
    step(); step();
    chk("hold_valid", 32'(pkt_valid), 32'd1);
    chk("lit_hold_len", 32'(pkt_len), 32'd2);
    chk("hold_no_clear", 32'(clr_cnt), 32'd0);
    ack_pkt();

    // Reset after 5 payload bytes, with a byte strobed during reset
    clr_cnt = 0; perr_cnt = 0;
    step(); rcving = 1'b1;
    step(); w_enable = 1'b1; rcv_data = 8'hA5;
    for (int i = 0; i < 5; i++) begin
      step(); rcv_data = payload[i]; push_wr(i, payload[i]);
    end
    step(); rst = 1'b1;
    step();
    chk_zero("reset_mid_pkt");
    rst = 1'b0; w_enable = 1'b0; rcving = 1'b0;
    step(); step(); step();
    chk("rst_pending_writes", 32'(exp_q.size()), 32'd0);
    chk("rst_no_clear", 32'(clr_cnt), 32'd0);
    chk("rst_no_pkt_err", 32'(perr_cnt), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);

    // Recovery packet starts at address 0
    send_pkt(8'hC3, 1, -1, 1'b0, 1'b0, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
